// File: rtl/call_display_queue.sv
// rtl/call_display_queue.sv - FIFO-buffered call events shown on the hall display with hold timer and blink
module call_display_queue #(
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 8,
   parameter int BLINK_HALF  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     call_valid,
   input  logic [2:0]               call_counter,
   input  logic [5:0]               call_number,
   input  logic                     flush,
   output logic [2:0]               disp_counter,
   output logic [5:0]               disp_number,
   output logic                     disp_active,
   output logic                     blink,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     drop,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(HOLD_CYCLES);
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   typedef enum logic [0:0] {IDLE, SHOW} state_t;

   state_t          state_q;
   logic [8:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [TW-1:0]   timer_q;
   logic [BW-1:0]   bcnt_q;
   logic [2:0]      disp_counter_q;
   logic [5:0]      disp_number_q;
   logic            disp_active_q, blink_q, drop_q, overflow_q;

   logic valid_code, push_req, full, hold_done, pop, push, lose;

   always_comb begin
      valid_code = (call_counter >= 3'd1) && (call_counter <= 3'd5);
      push_req   = call_valid && valid_code && !flush;
      full       = (count_q == CW'(DEPTH));
      hold_done  = (state_q == SHOW) && (timer_q == TW'(HOLD_CYCLES - 1));
      // Pop samples the pre-edge count, so a call pushed into an empty queue waits a cycle.
      pop        = !flush && (count_q != '0) && ((state_q == IDLE) || hold_done);
      push       = push_req && (!full || pop);
      lose       = push_req && full && !pop;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {call_counter, call_number};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         timer_q        <= '0;
         bcnt_q         <= '0;
         disp_counter_q <= '0;
         disp_number_q  <= '0;
         disp_active_q  <= 1'b0;
         blink_q        <= 1'b0;
         drop_q         <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= lose;
         if (lose) overflow_q <= 1'b1;

         if (flush) begin
            state_q       <= IDLE;
            disp_active_q <= 1'b0;
            blink_q       <= 1'b0;
            timer_q       <= '0;
            bcnt_q        <= '0;
         end else if (pop) begin
            {disp_counter_q, disp_number_q} <= mem_q[rd_ptr_q];
            state_q       <= SHOW;
            disp_active_q <= 1'b1;
            blink_q       <= 1'b1;
            timer_q       <= '0;
            bcnt_q        <= '0;
         end else if (hold_done) begin
            state_q       <= IDLE;
            disp_active_q <= 1'b0;
            blink_q       <= 1'b0;
         end else if (state_q == SHOW) begin
            timer_q <= timer_q + TW'(1);
            if (bcnt_q == BW'(BLINK_HALF - 1)) begin
               bcnt_q  <= '0;
               blink_q <= ~blink_q;
            end else begin
               bcnt_q <= bcnt_q + BW'(1);
            end
         end
      end
   end

   assign disp_counter = disp_counter_q;
   assign disp_number  = disp_number_q;
   assign disp_active  = disp_active_q;
   assign blink        = blink_q;
   assign fifo_count   = count_q;
   assign drop         = drop_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_call_display_queue.sv
// tb/tb_call_display_queue.sv - self-checking bench for call_display_queue
module tb_call_display_queue;
   localparam int DEPTH = 4;
   localparam int HOLD  = 8;
   localparam int BH    = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       call_valid;
   logic [2:0] call_counter;
   logic [5:0] call_number;
   logic       flush;
   logic [2:0] disp_counter;
   logic [5:0] disp_number;
   logic       disp_active, blink, drop, overflow;
   logic [2:0] fifo_count;

   always #5 clk = ~clk;

   call_display_queue #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .BLINK_HALF(BH)) dut (
      .clk(clk), .rst(rst), .call_valid(call_valid), .call_counter(call_counter),
      .call_number(call_number), .flush(flush), .disp_counter(disp_counter),
      .disp_number(disp_number), .disp_active(disp_active), .blink(blink),
      .fifo_count(fifo_count), .drop(drop), .overflow(overflow)
   );

   int checks = 0;
   int failures = 0;

   // reference model state
   logic [8:0] mq[$];
   bit         m_show;
   int         m_el;
   logic [2:0] m_dc;
   logic [5:0] m_dn;
   bit         m_drop, m_ovf;

   // observation of what was shown
   logic [8:0] shown[$];
   int         peak, run, max_run;
   bit         prev_act;
   logic [8:0] prev_disp;

   typedef struct {
      logic v; logic [2:0] c; logic [5:0] n; logic f;
      logic ea; logic eb; logic [2:0] ec; logic [5:0] en; int ecnt; logic ed;
   } vec_t;
   vec_t tbl[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      mq.delete(); m_show = 0; m_el = 0; m_dc = '0; m_dn = '0; m_drop = 0; m_ovf = 0;
   endfunction

   function automatic void model_step(logic v, logic [2:0] c, logic [5:0] n, logic f);
      bit popped = 0;
      bit was_full = (mq.size() == DEPTH);
      m_drop = 0;
      if (f) begin
         mq.delete(); m_show = 0; m_el = 0;
         return;
      end
      if (mq.size() > 0 && (!m_show || m_el == HOLD - 1)) begin
         {m_dc, m_dn} = mq.pop_front();
         m_show = 1; m_el = 0; popped = 1;
      end else if (m_show) begin
         if (m_el == HOLD - 1) m_show = 0;
         else m_el++;
      end
      if (v && c >= 1 && c <= 5) begin
         if (was_full && !popped) begin m_drop = 1; m_ovf = 1; end
         else mq.push_back({c, n});
      end
   endfunction

   task automatic check_model();
      chk("m_active",  disp_active, m_show);
      chk("m_blink",   blink, (m_show && ((m_el / BH) % 2 == 0)) ? 1 : 0);
      chk("m_counter", disp_counter, m_dc);
      chk("m_number",  disp_number, m_dn);
      chk("m_count",   fifo_count, mq.size());
      chk("m_drop",    drop, m_drop);
      chk("m_ovf",     overflow, m_ovf);
   endtask

   task automatic clear_obs();
      shown.delete(); peak = 0; run = 0; max_run = 0; prev_act = 0; prev_disp = '0;
   endtask

   task automatic step(input logic v, input logic [2:0] c, input logic [5:0] n, input logic f);
      call_valid = v; call_counter = c; call_number = n; flush = f;
      @(posedge clk);
      model_step(v, c, n, f);
      #1;
      check_model();
      if (fifo_count > peak) peak = fifo_count;
      if (disp_active) begin
         run++;
         if (run > max_run) max_run = run;
         if (!prev_act || {disp_counter, disp_number} != prev_disp)
            shown.push_back({disp_counter, disp_number});
      end else run = 0;
      prev_act = disp_active; prev_disp = {disp_counter, disp_number};
      @(negedge clk);
      call_valid = 0; flush = 0; call_counter = '0; call_number = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 3'd0, 6'd0, 0);
   endtask

   initial begin
      rst = 0; call_valid = 0; call_counter = '0; call_number = '0; flush = 0;
      model_reset(); clear_obs();
      #1;
      check_model();
      @(negedge clk); @(negedge clk);
      rst = 1;

      // single call blink pattern, then invalid counter codes
      tbl[0]  = '{1'b1, 3'd2, 6'd5, 1'b0, 1'b0, 1'b0, 3'd0, 6'd0, 1, 1'b0};
      tbl[1]  = '{1'b0, 3'd0, 6'd0, 1'b0, 1'b1, 1'b1, 3'd2, 6'd5, 0, 1'b0};
      tbl[2]  = '{1'b0, 3'd0, 6'd0, 1'b0, 1'b1, 1'b1, 3'd2, 6'd5, 0, 1'b0};
      tbl[3]  = '{1'b0, 3'd0, 6'd0, 1'b0, 1'b1, 1'b0, 3'd2, 6'd5, 0, 1'b0};
      tbl[4]  = '{1'b0, 3'd0, 6'd0, 1'b0, 1'b1, 1'b0, 3'd2, 6'd5, 0, 1'b0};
      tbl[5]  = '{1'b0, 3'd0, 6'd0, 1'b0, 1'b1, 1'b1, 3'd2, 6'd5, 0, 1'b0};
      tbl[6]  = '{1'b0, 3'd0, 6'd0, 1'b0, 1'b1, 1'b1, 3'd2, 6'd5, 0, 1'b0};
      tbl[7]  = '{1'b0, 3'd0, 6'd0, 1'b0, 1'b1, 1'b0, 3'd2, 6'd5, 0, 1'b0};
      tbl[8]  = '{1'b0, 3'd0, 6'd0, 1'b0, 1'b1, 1'b0, 3'd2, 6'd5, 0, 1'b0};
      tbl[9]  = '{1'b0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0, 3'd2, 6'd5, 0, 1'b0};
      tbl[10] = '{1'b1, 3'd0, 6'd9, 1'b0, 1'b0, 1'b0, 3'd2, 6'd5, 0, 1'b0};
      tbl[11] = '{1'b1, 3'd7, 6'd9, 1'b0, 1'b0, 1'b0, 3'd2, 6'd5, 0, 1'b0};
      tbl[12] = '{1'b1, 3'd6, 6'd9, 1'b0, 1'b0, 1'b0, 3'd2, 6'd5, 0, 1'b0};
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].v, tbl[i].c, tbl[i].n, tbl[i].f);
         chk($sformatf("tbl%0d_active", i),  disp_active,  tbl[i].ea);
         chk($sformatf("tbl%0d_blink", i),   blink,        tbl[i].eb);
         chk($sformatf("tbl%0d_counter", i), disp_counter, tbl[i].ec);
         chk($sformatf("tbl%0d_number", i),  disp_number,  tbl[i].en);
         chk($sformatf("tbl%0d_count", i),   fifo_count,   tbl[i].ecnt);
         chk($sformatf("tbl%0d_drop", i),    drop,         tbl[i].ed);
      end

      // three back-to-back calls
      clear_obs();
      step(1, 3'd1, 6'd1, 0); step(1, 3'd2, 6'd2, 0); step(1, 3'd3, 6'd3, 0);
      idle(30);
      chk("t3_run", max_run, 24);
      chk("t3_peak", peak, 2);
      chk("t3_nshown", shown.size(), 3);
      for (int i = 0; i < 3 && i < shown.size(); i++)
         chk($sformatf("t3_order%0d", i), shown[i], {3'(i + 1), 6'(i + 1)});

      // six calls: fill the queue and drop the last one
      clear_obs();
      for (int i = 0; i < 6; i++) begin
         step(1, 3'((i % 5) + 1), 6'(10 + i), 0);
         if (i == 4) chk("t4_full", fifo_count, 4);
         if (i == 4) chk("t4_nodrop", drop, 0);
         if (i == 5) begin chk("t4_drop", drop, 1); chk("t4_ovf", overflow, 1); end
      end
      step(0, 3'd0, 6'd0, 0);
      chk("t4_drop_pulse", drop, 0);
      chk("t4_ovf_sticky", overflow, 1);
      idle(45);
      chk("t4_nshown", shown.size(), 5);
      for (int i = 0; i < 5 && i < shown.size(); i++)
         chk($sformatf("t4_order%0d", i), shown[i], {3'(i + 1), 6'(10 + i)});
      chk("t4_ovf_end", overflow, 1);

      // flush during display with two queued and a simultaneous call
      step(1, 3'd1, 6'd21, 0); step(1, 3'd2, 6'd22, 0); step(1, 3'd3, 6'd23, 0);
      idle(2);
      chk("t6_pre_count", fifo_count, 2);
      step(1, 3'd4, 6'd44, 1);
      chk("t6_count", fifo_count, 0);
      chk("t6_active", disp_active, 0);
      chk("t6_counter", disp_counter, 1);
      chk("t6_number", disp_number, 21);
      chk("t6_drop", drop, 0);
      step(1, 3'd5, 6'd50, 0);
      step(0, 3'd0, 6'd0, 0);
      chk("t6_new_active", disp_active, 1);
      chk("t6_new_counter", disp_counter, 5);
      chk("t6_new_number", disp_number, 50);
      idle(10);

      // async reset in the middle of a display with calls pending
      step(1, 3'd2, 6'd31, 0); step(1, 3'd3, 6'd32, 0); step(1, 3'd4, 6'd33, 0);
      idle(2);
      rst = 0;
      #1;
      chk("t1_active", disp_active, 0);
      chk("t1_blink", blink, 0);
      chk("t1_counter", disp_counter, 0);
      chk("t1_number", disp_number, 0);
      chk("t1_count", fifo_count, 0);
      chk("t1_drop", drop, 0);
      chk("t1_ovf", overflow, 0);
      model_reset();
      @(negedge clk);
      rst = 1;
      step(0, 3'd0, 6'd0, 0);
      chk("t1_count_after", fifo_count, 0);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)), 6'($urandom),
              $urandom_range(0, 39) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
